btn_bank_debouncer: RTL and testbench

Multi-channel successor to the single-button debouncer. It synchronises and debounces NUM_BTNS button inputs independently. Each channel uses a stable-for-N integrating debounce rather than a lockout, and emits a debounced level plus press, release, long-press and auto-repeat events. It sits between the board button pins and the game/menu control logic, so consumers receive clean single-cycle events.

---
 rtl/btn_bank_debouncer_if.sv | 11 +
 rtl/btn_bank_debouncer_channel.sv | 84 ++++++++
 rtl/btn_bank_debouncer.sv | 57 +++++
 tb/tb_btn_bank_debouncer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_bank_debouncer_if.sv
// btn_bank_debouncer_if: raw button pins in, debounced levels and single-cycle events out
interface btn_bank_debouncer_if #(parameter int NUM_BTNS = 4);
  logic [NUM_BTNS-1:0] noisyIn;
  logic [NUM_BTNS-1:0] debounced;
  logic [NUM_BTNS-1:0] pressPulse;
  logic [NUM_BTNS-1:0] releasePulse;
  logic [NUM_BTNS-1:0] longPress;
  logic [NUM_BTNS-1:0] repeatPulse;
  modport master (output noisyIn, input debounced, pressPulse, releasePulse, longPress, repeatPulse);
  modport slave (input noisyIn, output debounced, pressPulse, releasePulse, longPress, repeatPulse);
endinterface

// File: rtl/btn_bank_debouncer_channel.sv
// btn_channel: one button's synchroniser, integrating debounce, press/hold FSM and event pulses
module btn_channel #(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int LONGPRESS_MS = 1,
  parameter int REPEAT_MS = 0,
  parameter int DW = 1,
  parameter int MW = 1,
  parameter int RW = 1,
  parameter logic IDLE_STATE = 1'b1
) (
  input logic clk,
  input logic reset,
  input logic tick,
  input logic noisyIn,
  output logic debounced,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPress,
  output logic repeatPulse
);
  typedef enum logic [1:0] {RELEASED, PRESSED, HELD} chState_t;
  chState_t state, stateNext;
  logic sync1, sync2, s, accept;
  logic pressNext, releaseNext, repeatNext;
  logic [DW-1:0] stabCnt, stabNext;
  logic [MW-1:0] msCnt, msNext;
  logic [RW-1:0] repCnt, repNext;
  assign s = sync2 ^ IDLE_STATE;
  assign debounced = state != RELEASED;
  assign longPress = state == HELD;
  // next-state: a debounce accept always wins, so release suppresses any coincident repeat
  always_comb begin
    accept = (s != debounced) && (stabCnt == DW'(DEBOUNCE_CYCLES - 1));
    stabNext = (s == debounced || accept) ? '0 : stabCnt + 1'b1;
    stateNext = state;
    msNext = msCnt;
    repNext = repCnt;
    pressNext = 1'b0;
    releaseNext = 1'b0;
    repeatNext = 1'b0;
    if (accept && state == RELEASED) begin
      stateNext = PRESSED;
      msNext = '0;
      pressNext = 1'b1;
    end else if (accept) begin
      stateNext = RELEASED;
      releaseNext = 1'b1;
    end else if (tick && state == PRESSED) begin
      msNext = msCnt + 1'b1;
      if (msCnt == MW'(LONGPRESS_MS - 1)) begin
        stateNext = HELD;
        repNext = '0;
        repeatNext = REPEAT_MS != 0;
      end
    end else if (tick && state == HELD) begin
      repNext = (repCnt == RW'(REPEAT_MS - 1)) ? '0 : repCnt + 1'b1;
      repeatNext = (REPEAT_MS != 0) && (repCnt == RW'(REPEAT_MS - 1));
    end
  end
  // registers: two-flop synchroniser, counters, FSM state and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_STATE;
      sync2 <= IDLE_STATE;
      state <= RELEASED;
      stabCnt <= '0;
      msCnt <= '0;
      repCnt <= '0;
      pressPulse <= 1'b0;
      releasePulse <= 1'b0;
      repeatPulse <= 1'b0;
    end else begin
      sync1 <= noisyIn;
      sync2 <= sync1;
      state <= stateNext;
      stabCnt <= stabNext;
      msCnt <= msNext;
      repCnt <= repNext;
      pressPulse <= pressNext;
      releasePulse <= releaseNext;
      repeatPulse <= repeatNext;
    end
  end
endmodule

// File: rtl/btn_bank_debouncer.sv
// btn_bank_debouncer: shared millisecond prescaler feeding NUM_BTNS independent debounce channels
module btn_bank_debouncer #(
  parameter int NUM_BTNS = 4,
  parameter int CLKIN_FREQ = 27_000_000,
  parameter real DEBOUNCE_PERIOD = 1e-3,
  parameter int LONGPRESS_MS = 500,
  parameter int REPEAT_MS = 100,
  parameter logic IDLE_STATE = 1'b1
) (
  input logic clk,
  input logic reset,
  btn_bank_debouncer_if.slave bus
);
  localparam int DEB_RAW = $rtoi(real'(CLKIN_FREQ) * DEBOUNCE_PERIOD + 0.5);
  localparam int DEBOUNCE_CYCLES = DEB_RAW < 1 ? 1 : DEB_RAW;
  localparam int TICK_CYCLES = CLKIN_FREQ / 1000 < 1 ? 1 : CLKIN_FREQ / 1000;
  localparam int LP_MS = LONGPRESS_MS < 1 ? 1 : LONGPRESS_MS;
  localparam int TW = $clog2(TICK_CYCLES < 2 ? 2 : TICK_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES < 2 ? 2 : DEBOUNCE_CYCLES);
  localparam int MW = $clog2(LP_MS < 2 ? 2 : LP_MS);
  localparam int RW = $clog2(REPEAT_MS < 2 ? 2 : REPEAT_MS);
  logic [TW-1:0] preCnt;
  logic tick;
  logic [NUM_BTNS-1:0] debV, pressV, releaseV, longV, repeatV;
  assign tick = preCnt == TW'(TICK_CYCLES - 1);
  assign bus.debounced = debV;
  assign bus.pressPulse = pressV;
  assign bus.releasePulse = releaseV;
  assign bus.longPress = longV;
  assign bus.repeatPulse = repeatV;
  // free-running prescaler; tick marks the last cycle of each millisecond
  always_ff @(posedge clk) begin
    if (reset) preCnt <= '0;
    else preCnt <= tick ? '0 : preCnt + 1'b1;
  end
  for (genvar i = 0; i < NUM_BTNS; i++) begin : gCh
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONGPRESS_MS(LP_MS),
      .REPEAT_MS(REPEAT_MS),
      .DW(DW),
      .MW(MW),
      .RW(RW),
      .IDLE_STATE(IDLE_STATE)
    ) uCh (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .noisyIn(bus.noisyIn[i]),
      .debounced(debV[i]),
      .pressPulse(pressV[i]),
      .releasePulse(releaseV[i]),
      .longPress(longV[i]),
      .repeatPulse(repeatV[i])
    );
  end
endmodule

// File: tb/tb_btn_bank_debouncer.sv
// tb_btn_bank_debouncer: table vectors, hand-written corner sequences and random stimulus against a timing-rule model
module tb_btn_bank_debouncer;
  localparam int N = 4;
  localparam int D = 10;
  localparam int LP = 50;
  localparam int RP = 20;
  localparam logic IDLE = 1'b1;
  localparam logic [N-1:0] IDLEV = {N{IDLE}};
  typedef struct {
    int ch;
    int lowLen;
    int expPresses;
    int expPressAt;
    int expRelAt;
    int expLong;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int nAssert = 0;
  int nFail = 0;
  logic [N-1:0] rawHist[$];
  int lastAgree[N];
  int pressEdge[N];
  logic [N-1:0] mDeb = '0, mPress = '0, mRel = '0, mLong = '0, mRep = '0;
  btn_bank_debouncer_if #(.NUM_BTNS(N)) bus ();
  btn_bank_debouncer #(
    .NUM_BTNS(N),
    .CLKIN_FREQ(1000),
    .DEBOUNCE_PERIOD(0.01),
    .LONGPRESS_MS(LP),
    .REPEAT_MS(RP),
    .IDLE_STATE(IDLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask
  // Model: a channel flips once its synchronised level (raw input two edges earlier)
  // has differed from the debounced level for D consecutive edges; hold and repeat
  // events follow from elapsed edges since the press, since the ms tick fires every cycle here.
  task automatic step();
    int e;
    logic [N-1:0] s;
    e = cyc + 1;
    if (reset) begin
      rawHist.delete();
      rawHist.push_back(IDLEV);
      rawHist.push_back(IDLEV);
      mDeb = '0;
      mPress = '0;
      mRel = '0;
      mLong = '0;
      mRep = '0;
      for (int c = 0; c < N; c++) lastAgree[c] = e;
    end else begin
      s = rawHist.pop_front() ^ IDLEV;
      rawHist.push_back(bus.noisyIn);
      mPress = '0;
      mRel = '0;
      mRep = '0;
      for (int c = 0; c < N; c++) begin
        if (s[c] == mDeb[c]) lastAgree[c] = e;
        else if (e - lastAgree[c] == D) begin
          lastAgree[c] = e;
          mDeb[c] = s[c];
          mPress[c] = s[c];
          mRel[c] = !s[c];
          if (s[c]) pressEdge[c] = e;
        end
        mLong[c] = mDeb[c] && (e - pressEdge[c] >= LP);
        mRep[c] = mLong[c] && ((e - pressEdge[c] - LP) % RP == 0);
      end
    end
    @(posedge clk);
    #1;
    cyc = e;
    chk("model_debounced", int'(bus.debounced), int'(mDeb));
    chk("model_pressPulse", int'(bus.pressPulse), int'(mPress));
    chk("model_releasePulse", int'(bus.releasePulse), int'(mRel));
    chk("model_longPress", int'(bus.longPress), int'(mLong));
    chk("model_repeatPulse", int'(bus.repeatPulse), int'(mRep));
  endtask
  task automatic doReset();
    reset = 1'b1;
    bus.noisyIn = IDLEV;
    step();
    step();
    reset = 1'b0;
  endtask
  vec_t vt[5];
  int np, pAt, rAt, sawLong, nRep, lpAt, relDeb, relLong, relRep, other;
  int pAt1, pAt3, rAt3, rel1;
  int repAt[8];
  int holdLeft[N];
  initial begin
    vt[0] = '{0, 1, 0, -1, -1, 0};
    vt[1] = '{1, 9, 0, -1, -1, 0};
    vt[2] = '{2, 10, 1, 12, 22, 0};
    vt[3] = '{3, 25, 1, 12, 37, 0};
    vt[4] = '{0, 80, 1, 12, 92, 1};
    bus.noisyIn = IDLEV;
    doReset();
    chk("reset_debounced", int'(bus.debounced), 0);
    chk("reset_pressPulse", int'(bus.pressPulse), 0);
    chk("reset_releasePulse", int'(bus.releasePulse), 0);
    chk("reset_longPress", int'(bus.longPress), 0);
    chk("reset_repeatPulse", int'(bus.repeatPulse), 0);
    // table-driven single low pulses of various lengths
    for (int k = 0; k < 5; k++) begin
      np = 0;
      pAt = -1;
      rAt = -1;
      sawLong = 0;
      doReset();
      for (int t = 0; t < vt[k].lowLen + 40; t++) begin
        bus.noisyIn[vt[k].ch] = (t < vt[k].lowLen) ? ~IDLE : IDLE;
        step();
        if (bus.pressPulse[vt[k].ch]) begin
          np++;
          pAt = t + 1;
        end
        if (bus.releasePulse[vt[k].ch]) rAt = t + 1;
        if (bus.longPress[vt[k].ch]) sawLong = 1;
      end
      chk($sformatf("tbl%0d_presses", k), np, vt[k].expPresses);
      chk($sformatf("tbl%0d_pressAt", k), pAt, vt[k].expPressAt);
      chk($sformatf("tbl%0d_releaseAt", k), rAt, vt[k].expRelAt);
      chk($sformatf("tbl%0d_long", k), sawLong, vt[k].expLong);
    end
    // clean press on channel 0
    doReset();
    np = 0;
    pAt = -1;
    other = 0;
    bus.noisyIn[0] = ~IDLE;
    for (int t = 0; t < 20; t++) begin
      step();
      if (bus.pressPulse[0]) begin
        np++;
        pAt = t + 1;
      end
      if (bus.pressPulse[N-1:1] != 0 || bus.debounced[N-1:1] != 0) other++;
    end
    chk("clean_pressAt", pAt, 12);
    chk("clean_pressCount", np, 1);
    chk("clean_otherChannels", other, 0);
    chk("clean_debounced", int'(bus.debounced), 1);
    // bounce: toggle every 3 cycles, last toggle at t=30 leaves the pin low
    doReset();
    np = 0;
    pAt = -1;
    for (int t = 0; t < 60; t++) begin
      if (t <= 30 && t % 3 == 0) bus.noisyIn[0] = ~bus.noisyIn[0];
      step();
      if (bus.pressPulse[0]) begin
        np++;
        pAt = t + 1;
      end
    end
    chk("bounce_pressCount", np, 1);
    chk("bounce_pressAt", pAt, 42);
    // glitch of 9 cycles on channel 2
    doReset();
    other = 0;
    bus.noisyIn[2] = ~IDLE;
    for (int t = 0; t < 40; t++) begin
      if (t == 9) bus.noisyIn[2] = IDLE;
      step();
      if ((bus.debounced | bus.pressPulse | bus.releasePulse | bus.longPress | bus.repeatPulse) != 0) other++;
    end
    chk("glitch_activity", other, 0);
    // long press on channel 1, released 150 cycles after accept
    doReset();
    nRep = 0;
    pAt = -1;
    lpAt = -1;
    rAt = -1;
    relDeb = -1;
    relLong = -1;
    relRep = -1;
    bus.noisyIn[1] = ~IDLE;
    for (int t = 0; t < 190; t++) begin
      if (t == 162) bus.noisyIn[1] = IDLE;
      step();
      if (bus.pressPulse[1]) pAt = t + 1;
      if (bus.longPress[1] && lpAt < 0) lpAt = t + 1;
      if (bus.repeatPulse[1]) begin
        if (nRep < 8) repAt[nRep] = t + 1;
        nRep++;
      end
      if (bus.releasePulse[1]) begin
        rAt = t + 1;
        relDeb = int'(bus.debounced[1]);
        relLong = int'(bus.longPress[1]);
        relRep = int'(bus.repeatPulse[1]);
      end
    end
    chk("long_pressAt", pAt, 12);
    chk("long_longAt", lpAt, 62);
    chk("long_repeatCount", nRep, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("long_repeat%0dAt", k), repAt[k], 62 + 20 * k);
    chk("long_releaseAt", rAt, 174);
    chk("long_relDebounced", relDeb, 0);
    chk("long_relLongPress", relLong, 0);
    chk("long_relRepeat", relRep, 0);
    // concurrency: channels 1 and 3 pressed together, channel 3 released after 20 cycles
    doReset();
    pAt1 = -1;
    pAt3 = -1;
    rAt3 = -1;
    rel1 = 0;
    bus.noisyIn[1] = ~IDLE;
    bus.noisyIn[3] = ~IDLE;
    for (int t = 0; t < 60; t++) begin
      if (t == 20) bus.noisyIn[3] = IDLE;
      step();
      if (bus.pressPulse[1]) pAt1 = t + 1;
      if (bus.pressPulse[3]) pAt3 = t + 1;
      if (bus.releasePulse[3]) rAt3 = t + 1;
      if (bus.releasePulse[1]) rel1++;
    end
    chk("conc_press1At", pAt1, 12);
    chk("conc_press3At", pAt3, 12);
    chk("conc_release3At", rAt3, 32);
    chk("conc_release1Count", rel1, 0);
    chk("conc_debounced", int'(bus.debounced), 2);
    // reset while channel 0 is held
    doReset();
    bus.noisyIn[0] = ~IDLE;
    for (int t = 0; t < 70; t++) step();
    chk("rst_heldBefore", int'(bus.longPress[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_debounced", int'(bus.debounced), 0);
    chk("rst_releasePulse", int'(bus.releasePulse), 0);
    chk("rst_longPress", int'(bus.longPress), 0);
    chk("rst_repeatPulse", int'(bus.repeatPulse), 0);
    pAt = -1;
    for (int t = 0; t < 30; t++) begin
      step();
      if (bus.pressPulse[0] && pAt < 0) pAt = t + 1;
    end
    chk("rst_repressAt", pAt, 12);
    // random bursts and holds on all channels with occasional reset
    doReset();
    for (int c = 0; c < N; c++) holdLeft[c] = $urandom_range(1, 30);
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (holdLeft[c] == 0) begin
          bus.noisyIn[c] = ~bus.noisyIn[c];
          holdLeft[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : $urandom_range(5, 120);
        end else holdLeft[c]--;
      end
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
